// File: rtl/floor_request_queue.sv
// Four-entry FIFO of elevator floor requests feeding the floor comparator.
// Optional macro QUEUE_DEDUP_EN drops requests for floors already queued.
module floor_request_queue (
    input  logic       clk,
    input  logic       reset,
    input  logic       reqValid,
    input  logic [1:0] reqFloor,
    input  logic       popReq,
    output logic [1:0] pos0Mem,
    output logic       pos0Valid,
    output logic [2:0] count,
    output logic       full,
    output logic       empty,
    output logic       reqDrop
);

    logic [1:0] mem [4];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [2:0] cnt;
    logic       drop_q;

    logic do_pop;
    logic dup;
    logic accept;

    assign do_pop = popReq && (cnt != 3'd0);

`ifdef QUEUE_DEDUP_EN
    // Compare only against entries that survive this cycle's pop.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) < cnt) && !(i == 0 && do_pop) &&
                (mem[rd_ptr + 2'(i)] == reqFloor))
                dup = 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign accept = reqValid && !dup && ((cnt != 3'd4) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            cnt    <= 3'd0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= reqValid && !accept;
            if (accept) begin
                mem[wr_ptr] <= reqFloor;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 2'd1;
            if (accept && !do_pop)
                cnt <= cnt + 3'd1;
            else if (do_pop && !accept)
                cnt <= cnt - 3'd1;
        end
    end

    assign count     = cnt;
    assign empty     = (cnt == 3'd0);
    assign full      = (cnt == 3'd4);
    assign pos0Valid = !empty;
    assign pos0Mem   = empty ? 2'b00 : mem[rd_ptr];
    assign reqDrop   = drop_q;

endmodule

// File: tb/tb_floor_request_queue.sv
// Directed self-checking bench for floor_request_queue.
// Expectations follow QUEUE_DEDUP_EN when the bench is built with it.
module tb_floor_request_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic       reqValid;
    logic [1:0] reqFloor;
    logic       popReq;
    logic [1:0] pos0Mem;
    logic       pos0Valid;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       reqDrop;

    int n_tests = 0;
    int n_fail  = 0;

    floor_request_queue dut (
        .clk       (clk),
        .reset     (reset),
        .reqValid  (reqValid),
        .reqFloor  (reqFloor),
        .popReq    (popReq),
        .pos0Mem   (pos0Mem),
        .pos0Valid (pos0Valid),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .reqDrop   (reqDrop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic v,
                        input logic [1:0] f, input logic p);
        reset    = r;
        reqValid = v;
        reqFloor = f;
        popReq   = p;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        reqValid = 1'b0;
        reqFloor = 2'd0;
        popReq   = 1'b0;
    endtask

    task automatic push(input logic [1:0] f);
        step(1'b0, 1'b1, f, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 1'b0, 2'd0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; reqValid = 1'b0; reqFloor = 2'd0; popReq = 1'b0;
        do_reset();
        do_reset();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", pos0Valid, 0);
        check("rst_head", pos0Mem, 0);
        check("rst_drop", reqDrop, 0);

        // reset then push
        push(2'd3);
        check("push_head", pos0Mem, 3);
        check("push_valid", pos0Valid, 1);
        check("push_count", count, 1);
        check("push_empty", empty, 0);

        // fill and overflow
        do_reset();
        push(2'd0); push(2'd1); push(2'd2); push(2'd3);
        check("fill_full", full, 1);
        check("fill_count", count, 4);
        check("fill_head", pos0Mem, 0);
        push(2'd2);
        check("ovf_drop", reqDrop, 1);
        check("ovf_count", count, 4);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check("ovf_drop_once", reqDrop, 0);
        check("ovf_count2", count, 4);

        // simultaneous push/pop when full (queue 0,1,2,3)
        step(1'b0, 1'b1, 2'd1, 1'b1);
`ifdef QUEUE_DEDUP_EN
        check("pp_drop", reqDrop, 1);
        check("pp_count", count, 3);
        check("pp_head", pos0Mem, 1);
        pop(); check("pp_ord1", pos0Mem, 2);
        pop(); check("pp_ord2", pos0Mem, 3);
        pop(); check("pp_empty", empty, 1);
`else
        check("pp_drop", reqDrop, 0);
        check("pp_count", count, 4);
        check("pp_full", full, 1);
        check("pp_head", pos0Mem, 1);
        pop(); check("pp_ord1", pos0Mem, 2);
        pop(); check("pp_ord2", pos0Mem, 3);
        pop(); check("pp_ord3", pos0Mem, 1);
        check("pp_cnt1", count, 1);
        pop(); check("pp_empty", empty, 1);
`endif

        // FIFO order
        do_reset();
        push(2'd1); push(2'd3); push(2'd0);
        check("fifo_count", count, 3);
        check("fifo_head0", pos0Mem, 1);
        pop(); check("fifo_head1", pos0Mem, 3);
        pop(); check("fifo_head2", pos0Mem, 0);
        check("fifo_valid2", pos0Valid, 1);
        pop();
        check("fifo_empty", empty, 1);
        check("fifo_head_z", pos0Mem, 0);
        check("fifo_valid", pos0Valid, 0);
        pop();
        check("pop_empty_cnt", count, 0);
        check("pop_empty_e", empty, 1);

        // dedup
        do_reset();
        push(2'd2);
        push(2'd2);
`ifdef QUEUE_DEDUP_EN
        check("dd_drop", reqDrop, 1);
        check("dd_count", count, 1);
`else
        check("dd_drop", reqDrop, 0);
        check("dd_count", count, 2);
`endif
        step(1'b0, 1'b1, 2'd2, 1'b1);
        check("dd_pp_drop", reqDrop, 0);
        check("dd_pp_head", pos0Mem, 2);
`ifdef QUEUE_DEDUP_EN
        check("dd_pp_count", count, 1);
`else
        check("dd_pp_count", count, 2);
`endif

        // reset mid-operation
        do_reset();
        push(2'd1); push(2'd2); push(2'd3);
        check("mid_count", count, 3);
        step(1'b1, 1'b1, 2'd0, 1'b1);
        check("mid_count0", count, 0);
        check("mid_empty", empty, 1);
        check("mid_valid", pos0Valid, 0);
        check("mid_drop", reqDrop, 0);
        push(2'd1);
        check("post_count", count, 1);
        check("post_head", pos0Mem, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/floor_request_queue.md
FLOOR_REQUEST_QUEUE -- requirements
Module: floor_request_queue

Interface
REQ-001 The block SHALL have port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port `reset`: input, 1 bit, synchronous, active-high reset.
REQ-003 The block SHALL have port `reqValid`: input, 1 bit, floor-request strobe, sampled each cycle.
REQ-004 The block SHALL have port `reqFloor`: input, 2 bits, requested floor 0..3, valid when `reqValid`=1.
REQ-005 The block SHALL have port `popReq`: input, 1 bit, one-cycle pulse from the controller when the head floor has been served.
REQ-006 The block SHALL have port `pos0Mem`: output, 2 bits, head-of-queue floor, feeding the floor comparator.
REQ-007 The block SHALL have port `pos0Valid`: output, 1 bit, 1 when `pos0Mem` holds a queued request.
REQ-008 The block SHALL have port `count`: output, 3 bits, number of queued entries, 0..4.
REQ-009 The block SHALL have ports `full` and `empty`: outputs, 1 bit each, asserted when `count`=4 and `count`=0 respectively.
REQ-010 The block SHALL have port `reqDrop`: output, 1 bit, one-cycle pulse when a presented request is discarded.

Function
REQ-011 The block SHALL implement a 4-entry, 2-bit-wide FIFO of floor requests with registered outputs.
REQ-012 A push SHALL occur when `reqValid`=1 and the request is accepted; an accepted request becomes visible in `count` on the next cycle.
REQ-013 `pos0Mem` SHALL equal the oldest entry while `count`>0; when empty, `pos0Mem` SHALL be 2'b00 and `pos0Valid`=0.
REQ-014 A push into an empty queue SHALL appear on `pos0Mem`, with `pos0Valid`=1, one cycle after the `reqValid` cycle.
REQ-015 A pop SHALL occur when `popReq`=1 and `count`>0: the head is removed and the next-oldest entry appears on `pos0Mem` the following cycle.
REQ-016 `popReq` with `count`=0 SHALL be ignored, with no state change.
REQ-017 Push and pop in the same cycle SHALL both take effect; `count` is unchanged, and the pushed entry goes to the tail.
REQ-018 A push when `full`=1 and no pop in the same cycle SHALL be discarded, and `reqDrop` SHALL be 1 on the next cycle.
REQ-019 A push when `full`=1 and a pop in the same cycle SHALL be accepted, with `count` remaining 4.
REQ-020 Read and write pointers SHALL be 2 bits and wrap from 3 to 0; `count` SHALL never exceed 4 or go below 0.
REQ-021 `full`, `empty`, `count` and `pos0Valid` SHALL be mutually consistent in every cycle.

Reset
REQ-022 While `reset`=1 at a rising edge, the block SHALL clear pointers and `count` to 0 and set `pos0Mem`=2'b00, `pos0Valid`=0, `empty`=1, `full`=0 and `reqDrop`=0.
REQ-023 `reset` SHALL take priority over simultaneous `reqValid` and `popReq`, and all queued requests SHALL be lost.
REQ-024 After `reset` deasserts, the first push SHALL be accepted with no idle cycles required.

Configuration
REQ-025 Macro `QUEUE_DEDUP_EN` defined: a request whose floor matches any entry remaining after this cycle's pop SHALL be discarded, pulsing `reqDrop`.
REQ-026 Under `QUEUE_DEDUP_EN`, a request matching the head being popped in the same cycle SHALL be accepted.
REQ-027 Macro `QUEUE_DEDUP_EN` undefined: duplicate floors SHALL be enqueued like any other request, and `reqDrop` SHALL pulse only on overflow.

Verification
REQ-028 Bench scenario "reset then push" SHALL check: reset, then `reqValid`=1 with `reqFloor`=3 for 1 cycle -> next cycle `pos0Mem`=3, `pos0Valid`=1, `count`=1, `empty`=0.
REQ-029 Bench scenario "fill and overflow" SHALL check: push floors 0,1,2,3 -> `full`=1, `count`=4; then push 2 with no pop -> `reqDrop` pulses once and `count` stays 4.
REQ-030 Bench scenario "FIFO order" SHALL check: with the queue holding 1,3,0, pulse `popReq` three times -> `pos0Mem` reads 3, then 0, then `empty`=1 with `pos0Mem`=0.
REQ-031 Bench scenario "simultaneous push/pop when full" SHALL check: queue holds 0,1,2,3; push 1 together with `popReq` -> `count`=4 and the order becomes 1,2,3,1 without `QUEUE_DEDUP_EN`; with `QUEUE_DEDUP_EN`, push 1 is dropped.
REQ-032 Bench scenario "dedup" SHALL check: with `QUEUE_DEDUP_EN`, queue holds 2; push 2 -> `reqDrop` pulses and `count`=1; push 2 together with `popReq` -> accepted, `count`=1, `pos0Mem`=2.
REQ-033 Bench scenario "reset mid-operation" SHALL check: queue holds 3 entries; assert `reset` together with `reqValid` and `popReq` -> next cycle `count`=0, `empty`=1, `pos0Valid`=0.
